// File: rtl/div_float.sv
// div_float: iterative IEEE-754 single-precision divider.
// Radix-2 restoring mantissa division over 25 cycles, truncated result,
// denormals flushed to zero, valid/busy request and response handshakes.
module div_float (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iDATA_REQ,
  output logic        oDATA_BUSY,
  input  logic [31:0] iDATA_A,
  input  logic [31:0] iDATA_B,
  output logic        oDATA_VALID,
  input  logic        iDATA_BUSY,
  output logic [31:0] oDATA_DATA
);

  localparam int unsigned RW        = 25;
  localparam int unsigned DW        = 24;
  localparam int unsigned LAST_ITER = 24;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_NORM, S_DONE} state_t;

  state_t          state_q;
  logic [4:0]      cnt_q;
  logic [RW-1:0]   r_q;
  logic [DW-1:0]   d_q;
  logic [RW-1:0]   q_q;
  logic [7:0]      expa_q;
  logic [7:0]      expb_q;
  logic            sign_q;
  logic            spec_q;
  logic [31:0]     spec_res_q;
  logic            valid_q;
  logic [31:0]     data_q;

  logic            sign_a, sign_b;
  logic [7:0]      exp_a, exp_b;
  logic [22:0]     fract_a, fract_b;
  logic            a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, s_d;
  logic            spec_d;
  logic [31:0]     spec_res_d;
  logic            ge;
  logic [RW-1:0]   r_pre;
  logic [RW-1:0]   r_d;
  logic [RW-1:0]   q_d;
  logic signed [9:0] e_d;
  logic [22:0]     mant_d;
  logic [31:0]     res_d;

  assign sign_a  = iDATA_A[31];
  assign exp_a   = iDATA_A[30:23];
  assign fract_a = iDATA_A[22:0];
  assign sign_b  = iDATA_B[31];
  assign exp_b   = iDATA_B[30:23];
  assign fract_b = iDATA_B[22:0];

  assign oDATA_BUSY  = (state_q != S_IDLE);
  assign oDATA_VALID = valid_q;
  assign oDATA_DATA  = data_q;

  // Operand classification and special-case result, captured at accept
  always_comb begin
    a_zero     = (exp_a == 8'd0);
    a_inf      = (exp_a == 8'hFF) && (fract_a == 23'd0);
    a_nan      = (exp_a == 8'hFF) && (fract_a != 23'd0);
    b_zero     = (exp_b == 8'd0);
    b_inf      = (exp_b == 8'hFF) && (fract_b == 23'd0);
    b_nan      = (exp_b == 8'hFF) && (fract_b != 23'd0);
    s_d        = sign_a ^ sign_b;
    spec_d     = 1'b1;
    spec_res_d = 32'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res_d = 32'h7FC0_0000;
    end else if (a_inf) begin
      spec_res_d = {s_d, 8'hFF, 23'd0};
    end else if (b_inf) begin
      spec_res_d = {s_d, 31'd0};
    end else if (b_zero) begin
      spec_res_d = {s_d, 8'hFF, 23'd0};
    end else if (a_zero) begin
      spec_res_d = {s_d, 31'd0};
    end else begin
      spec_d = 1'b0;
    end
  end

  // One restoring-division step: subtract when possible, then shift left
  always_comb begin
    ge    = (r_q >= {1'b0, d_q});
    r_pre = ge ? (r_q - {1'b0, d_q}) : r_q;
    r_d   = r_pre << 1;
    q_d   = {q_q[RW-2:0], ge};
  end

  // Normalize the quotient, compute the biased exponent and pack
  always_comb begin
    e_d    = 10'($signed({2'b00, expa_q}) - $signed({2'b00, expb_q}))
           + (q_q[24] ? 10'sd127 : 10'sd126);
    mant_d = q_q[24] ? q_q[23:1] : q_q[22:0];
    if (spec_q) begin
      res_d = spec_res_q;
    end else if (e_d >= 10'sd255) begin
      res_d = {sign_q, 8'hFF, 23'd0};
    end else if (e_d <= 10'sd0) begin
      res_d = {sign_q, 31'd0};
    end else begin
      res_d = {sign_q, e_d[7:0], mant_d};
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      r_q        <= '0;
      d_q        <= '0;
      q_q        <= '0;
      expa_q     <= 8'd0;
      expb_q     <= 8'd0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      valid_q    <= 1'b0;
      data_q     <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iDATA_REQ) begin
            r_q        <= {1'b0, 1'b1, fract_a};
            d_q        <= {1'b1, fract_b};
            q_q        <= '0;
            cnt_q      <= 5'd0;
            expa_q     <= exp_a;
            expb_q     <= exp_b;
            sign_q     <= s_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            state_q    <= S_DIV;
          end
        end
        S_DIV: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'(LAST_ITER)) begin
            state_q <= S_NORM;
          end
        end
        S_NORM: begin
          data_q  <= res_d;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          if (!iDATA_BUSY) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_float.sv
// tb_div_float: table-driven vectors with a scoreboard queue, plus
// backpressure and mid-operation reset sequences.
module tb_div_float;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC;
  logic        iDATA_REQ;
  logic        oDATA_BUSY;
  logic [31:0] iDATA_A;
  logic [31:0] iDATA_B;
  logic        oDATA_VALID;
  logic        iDATA_BUSY;
  logic [31:0] oDATA_DATA;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    string       name;
  } vec_t;

  vec_t vecs[$];

  div_float dut (
    .iCLOCK      (iCLOCK),
    .iRESET_SYNC (iRESET_SYNC),
    .iDATA_REQ   (iDATA_REQ),
    .oDATA_BUSY  (oDATA_BUSY),
    .iDATA_A     (iDATA_A),
    .iDATA_B     (iDATA_B),
    .oDATA_VALID (oDATA_VALID),
    .iDATA_BUSY  (iDATA_BUSY),
    .oDATA_DATA  (oDATA_DATA)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  // Runs one operation starting at a negedge in IDLE; hold = cycles of
  // downstream stall after the result appears.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_v, input int hold, input string nm);
    int n;
    logic [31:0] held;
    logic [31:0] want;
    iDATA_A    = a;
    iDATA_B    = b;
    iDATA_REQ  = 1'b1;
    iDATA_BUSY = (hold > 0);
    @(posedge iCLOCK);
    sb_q.push_back(exp_v);
    @(negedge iCLOCK);
    iDATA_REQ = 1'b0;
    iDATA_A   = $urandom;
    iDATA_B   = $urandom;
    chk({nm, "_busy_after_accept"}, 32'(oDATA_BUSY), 32'd1);
    n = 0;
    while (!oDATA_VALID && n < 100) begin
      @(negedge iCLOCK);
      n++;
    end
    if (!oDATA_VALID) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=novalid required=valid", nm);
      return;
    end
    chk({nm, "_latency"}, 32'(n), 32'd26);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb_empty actual=empty required=entry", nm);
    end else begin
      want = sb_q.pop_front();
      chk({nm, "_data"}, oDATA_DATA, want);
    end
    held = oDATA_DATA;
    for (int i = 0; i < hold; i++) begin
      iDATA_REQ = $urandom_range(0, 1);
      iDATA_A   = $urandom;
      @(negedge iCLOCK);
      chk({nm, "_hold_valid"}, 32'(oDATA_VALID), 32'd1);
      chk({nm, "_hold_data"}, oDATA_DATA, held);
      chk({nm, "_hold_busy"}, 32'(oDATA_BUSY), 32'd1);
    end
    iDATA_REQ  = 1'b0;
    iDATA_BUSY = 1'b0;
    @(negedge iCLOCK);
    chk({nm, "_valid_after_consume"}, 32'(oDATA_VALID), 32'd0);
    chk({nm, "_busy_after_consume"}, 32'(oDATA_BUSY), 32'd0);
    chk({nm, "_data_kept"}, oDATA_DATA, held);
  endtask

  initial begin
    int vcount;
    iRESET_SYNC = 1'b1;
    iDATA_REQ   = 1'b0;
    iDATA_A     = 32'd0;
    iDATA_B     = 32'd0;
    iDATA_BUSY  = 1'b0;

    vecs.push_back('{32'h40C00000, 32'h40000000, 32'h40400000, "six_div_two"});
    vecs.push_back('{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, "one_third_trunc"});
    vecs.push_back('{32'hC0000000, 32'h3F000000, 32'hC0800000, "neg_sign"});
    vecs.push_back('{32'h3F800000, 32'h3F800000, 32'h3F800000, "one_div_one"});
    vecs.push_back('{32'h3F800000, 32'h00000000, 32'h7F800000, "x_div_zero"});
    vecs.push_back('{32'h00000000, 32'h00000000, 32'h7FC00000, "zero_div_zero"});
    vecs.push_back('{32'h7F800000, 32'h7F800000, 32'h7FC00000, "inf_div_inf"});
    vecs.push_back('{32'h80000000, 32'h40000000, 32'h80000000, "negzero_div_x"});
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_a"});
    vecs.push_back('{32'hBF800000, 32'h7F800001, 32'h7FC00000, "nan_b"});
    vecs.push_back('{32'hFF800000, 32'h40000000, 32'hFF800000, "inf_div_fin"});
    vecs.push_back('{32'h3F800000, 32'hFF800000, 32'h80000000, "fin_div_inf"});
    vecs.push_back('{32'h7F000000, 32'h3E800000, 32'h7F800000, "overflow"});
    vecs.push_back('{32'h00800000, 32'h40000000, 32'h00000000, "underflow_e0"});
    vecs.push_back('{32'h00000001, 32'h3F800000, 32'h00000000, "denorm_flush"});

    repeat (2) @(posedge iCLOCK);
    @(negedge iCLOCK);
    iRESET_SYNC = 1'b0;
    chk("reset_valid", 32'(oDATA_VALID), 32'd0);
    chk("reset_data", oDATA_DATA, 32'd0);
    chk("reset_busy", 32'(oDATA_BUSY), 32'd0);

    vcount = vecs.size();
    for (int i = 0; i < vcount; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].exp_res, 0, vecs[i].name);
    end

    // Backpressure: result held for 10 stalled cycles, then a back-to-back op
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 10, "backpressure");
    do_op(32'hC0000000, 32'h3F000000, 32'hC0800000, 0, "after_bp");

    // Reset in the middle of the division aborts the operation
    iDATA_A   = 32'h3F800000;
    iDATA_B   = 32'h40400000;
    iDATA_REQ = 1'b1;
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    iDATA_REQ = 1'b0;
    repeat (10) @(negedge iCLOCK);
    iRESET_SYNC = 1'b1;
    @(negedge iCLOCK);
    iRESET_SYNC = 1'b0;
    chk("abort_busy", 32'(oDATA_BUSY), 32'd0);
    chk("abort_data", oDATA_DATA, 32'd0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge iCLOCK);
        if (oDATA_VALID) seen = 1'b1;
      end
      chk("abort_no_valid", 32'(seen), 32'd0);
    end
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 0, "after_reset");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
